// File: rtl/sys1_input_ctrl_if.sv
// sys1_input_ctrl_if
//  Groups the player-input signals of the SEGA System 1 input front end.
//  master: the source side. It drives the PS/2 key, the two joysticks and
//          vblank, and receives the core input bytes and coin_busy.
//  slave : the input controller itself.
//  Signals:
//   ps2_key   [10] event toggle, [9] pressed, [8:0] scan code
//   joystk1/2 HPS joysticks: [0]R [1]L [2]D [3]U [4..6]Trig1-3 [7]Start1 [8]Start2 [9]Coin
//   vblank    vertical blank, clk_sys domain
//   INP0..2   active-low input bytes to the game core
//   coin_busy coin pulse shaper is not idle
interface sys1_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystk1;
  logic [15:0] joystk2;
  logic        vblank;
  logic [7:0]  INP0;
  logic [7:0]  INP1;
  logic [7:0]  INP2;
  logic        coin_busy;

  modport master (
    output ps2_key, joystk1, joystk2, vblank,
    input  INP0, INP1, INP2, coin_busy
  );

  modport slave (
    input  ps2_key, joystk1, joystk2, vblank,
    output INP0, INP1, INP2, coin_busy
  );
endinterface

// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl
//  Player-input front end for the SEGA System 1 core. Decodes PS/2 key
//  events, merges them with the two HPS joysticks, shapes coin requests into
//  vblank-timed pulses with a minimum gap, and drives registered active-low
//  input bytes to the core.
//  Ports:
//   clk_sys  system clock
//   reset    synchronous, active-high reset
//   bus      sys1_input_ctrl_if.slave (ps2_key, joystk1/2, vblank in;
//            INP0/INP1/INP2, coin_busy out)
//
//  Coin FSM
//   state  | meaning
//   IDLE   | no pulse; starts one on a new request or a pending one
//   ACTIVE | coin bit asserted, counting vblank rising edges
//   GAP    | coin bit forced low, counting vblank rising edges
module sys1_input_ctrl #(
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 2,
  parameter int CABINET         = 0
) (
  input logic             clk_sys,
  input logic             reset,
  sys1_input_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  localparam logic [3:0] FRAMES_N = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_N    = 4'(COIN_GAP_FRAMES);
  localparam bit         GAP_ZERO = (COIN_GAP_FRAMES == 0);
  localparam bit         SPLIT    = (CABINET != 0);

  // PS/2 decode
  logic       old_toggle;
  logic       ps2_event;
  logic       pressed;
  logic [8:0] code;

  logic k_u, k_d, k_l, k_r, k_t1, k_t2, k_t3;
  logic k_f1, k_f2, k_s1, k_s2, k_c1, k_c2;
  logic k2_u, k2_d, k2_l, k2_r, k2_t1, k2_t2, k2_t3;

  assign ps2_event = bus.ps2_key[10] != old_toggle;
  assign pressed   = bus.ps2_key[9];
  assign code      = bus.ps2_key[8:0];

  always_ff @(posedge clk_sys) begin
    // Tracking the toggle during reset prevents a phantom event on release.
    old_toggle <= bus.ps2_key[10];
    if (reset) begin
      k_u  <= 1'b0; k_d  <= 1'b0; k_l  <= 1'b0; k_r  <= 1'b0;
      k_t1 <= 1'b0; k_t2 <= 1'b0; k_t3 <= 1'b0;
      k_f1 <= 1'b0; k_f2 <= 1'b0; k_s1 <= 1'b0; k_s2 <= 1'b0;
      k_c1 <= 1'b0; k_c2 <= 1'b0;
      k2_u  <= 1'b0; k2_d  <= 1'b0; k2_l  <= 1'b0; k2_r <= 1'b0;
      k2_t1 <= 1'b0; k2_t2 <= 1'b0; k2_t3 <= 1'b0;
    end else if (ps2_event) begin
      // Cursor keys match with or without the extended prefix.
      case (code[7:0])
        8'h75:   k_u <= pressed;
        8'h72:   k_d <= pressed;
        8'h6B:   k_l <= pressed;
        8'h74:   k_r <= pressed;
        default: ;
      endcase
      case (code)
        9'h029:  k_t1  <= pressed;
        9'h014:  k_t2  <= pressed;
        9'h011:  k_t3  <= pressed;
        9'h005:  k_f1  <= pressed;
        9'h006:  k_f2  <= pressed;
        9'h016:  k_s1  <= pressed;
        9'h01E:  k_s2  <= pressed;
        9'h02E:  k_c1  <= pressed;
        9'h036:  k_c2  <= pressed;
        9'h02D:  k2_u  <= pressed;
        9'h02B:  k2_d  <= pressed;
        9'h023:  k2_l  <= pressed;
        9'h034:  k2_r  <= pressed;
        9'h01C:  k2_t1 <= pressed;
        9'h01B:  k2_t2 <= pressed;
        9'h015:  k2_t3 <= pressed;
        default: ;
      endcase
    end
  end

  // Merge keyboard and joysticks
  logic p2_u, p2_d, p2_l, p2_r, p2_t1, p2_t2, p2_t3;
  logic p1_u, p1_d, p1_l, p1_r, p1_t1, p1_t2, p1_t3;
  logic start1, start2, coin_req;

  assign p2_u  = k2_u  | bus.joystk2[3];
  assign p2_d  = k2_d  | bus.joystk2[2];
  assign p2_l  = k2_l  | bus.joystk2[1];
  assign p2_r  = k2_r  | bus.joystk2[0];
  assign p2_t1 = k2_t1 | bus.joystk2[4];
  assign p2_t2 = k2_t2 | bus.joystk2[5];
  assign p2_t3 = k2_t3 | bus.joystk2[6];

  // Upright cabinets let either player's controls drive P1.
  assign p1_u  = k_u  | bus.joystk1[3] | (!SPLIT & p2_u);
  assign p1_d  = k_d  | bus.joystk1[2] | (!SPLIT & p2_d);
  assign p1_l  = k_l  | bus.joystk1[1] | (!SPLIT & p2_l);
  assign p1_r  = k_r  | bus.joystk1[0] | (!SPLIT & p2_r);
  assign p1_t1 = k_t1 | bus.joystk1[4] | (!SPLIT & p2_t1);
  assign p1_t2 = k_t2 | bus.joystk1[5] | (!SPLIT & p2_t2);
  assign p1_t3 = k_t3 | bus.joystk1[6] | (!SPLIT & p2_t3);

  assign start1   = k_s1 | k_f1 | bus.joystk1[7] | bus.joystk2[7];
  assign start2   = k_s2 | k_f2 | bus.joystk1[8] | bus.joystk2[8];
  assign coin_req = k_c1 | k_f1 | k_c2 | k_f2 | bus.joystk1[9] | bus.joystk2[9];

  logic unused_joy_bits;
  assign unused_joy_bits = ^{bus.joystk1[15:10], bus.joystk2[15:10]};

  // Registered player bytes
  logic [7:0] inp0_q, inp1_q;
  logic       start1_q, start2_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      inp0_q   <= 8'hFF;
      inp1_q   <= 8'hFF;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      inp0_q   <= ~{p1_l, p1_r, p1_u, p1_d, 1'b0, p1_t2, p1_t1, p1_t3};
      inp1_q   <= ~{p2_l, p2_r, p2_u, p2_d, 1'b0, p2_t2, p2_t1, p2_t3};
      start1_q <= start1;
      start2_q <= start2;
    end
  end

  // Coin pulse shaper
  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       pending;
  logic       coin_out;
  logic       vblank_d;
  logic       coin_req_d;
  logic       vb_rise;
  logic       req_rise;

  assign vb_rise  = bus.vblank & ~vblank_d;
  assign req_rise = coin_req & ~coin_req_d;
  assign cnt_inc  = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pending    <= 1'b0;
      coin_out   <= 1'b0;
      vblank_d   <= 1'b0;
      coin_req_d <= 1'b0;
    end else begin
      vblank_d   <= bus.vblank;
      coin_req_d <= coin_req;
      case (state)
        IDLE: begin
          if (req_rise || pending) begin
            state    <= ACTIVE;
            cnt      <= 4'd0;
            pending  <= 1'b0;
            coin_out <= 1'b1;
          end
        end
        ACTIVE: begin
          if (req_rise) pending <= 1'b1;
          if (vb_rise) begin
            if (cnt_inc == FRAMES_N) begin
              state    <= GAP;
              cnt      <= 4'd0;
              coin_out <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        GAP: begin
          if (req_rise) pending <= 1'b1;
          if (GAP_ZERO) begin
            state <= IDLE;
          end else if (vb_rise) begin
            if (cnt_inc == GAP_N) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state    <= IDLE;
          coin_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INP0      = inp0_q;
  assign bus.INP1      = inp1_q;
  assign bus.INP2      = {2'b11, ~start2_q, ~start1_q, 3'b111, ~coin_out};
  assign bus.coin_busy = (state != IDLE);

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// tb_sys1_input_ctrl
//  Directed bench for sys1_input_ctrl. Two instances share the same stimulus:
//  dut0 is the upright cabinet (CABINET=0), dut1 keeps players separate.
//  Expected output words {coin_busy, INP2, INP1, INP0} are queued when the
//  stimulus is applied and compared after the expected latency.
module tb_sys1_input_ctrl;
  localparam int CF = 3;
  localparam int GF = 2;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  sys1_input_ctrl_if bus0 ();
  sys1_input_ctrl_if bus1 ();

  assign bus1.ps2_key = bus0.ps2_key;
  assign bus1.joystk1 = bus0.joystk1;
  assign bus1.joystk2 = bus0.joystk2;
  assign bus1.vblank  = bus0.vblank;

  sys1_input_ctrl #(.COIN_FRAMES(CF), .COIN_GAP_FRAMES(GF), .CABINET(0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus0.slave));
  sys1_input_ctrl #(.COIN_FRAMES(CF), .COIN_GAP_FRAMES(GF), .CABINET(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus1.slave));

  typedef struct {
    string       tag;
    int          sel;
    logic [24:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic tog   = 1'b0;

  task automatic push(input string tag, input int sel, input logic busy,
                      input logic [7:0] i2, input logic [7:0] i1, input logic [7:0] i0);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = {busy, i2, i1, i0};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [24:0] o;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow: observed empty queue required an entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel == 0) o = {bus0.coin_busy, bus0.INP2, bus0.INP1, bus0.INP0};
    else            o = {bus1.coin_busy, bus1.INP2, bus1.INP1, bus1.INP0};
    assert (o === e.val) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", e.tag, o, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic pr, input logic [8:0] code);
    tog = ~tog;
    bus0.ps2_key = {tog, pr, code};
  endtask

  task automatic vb_pulse();
    bus0.vblank = 1'b1;
    step(1);
    bus0.vblank = 1'b0;
    step(3);
  endtask

  task automatic coin_tap();
    bus0.joystk1[9] = 1'b1;
    step(1);
    bus0.joystk1[9] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    bus0.ps2_key = 11'h000;
    bus0.joystk1 = 16'h0000;
    bus0.joystk2 = 16'h0000;
    bus0.vblank  = 1'b0;
    step(3);
    // Toggle changes while reset is held: must not decode after release.
    bus0.ps2_key = {1'b1, 1'b1, 9'h075};
    tog = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    push("reset_dut0", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); check();
    push("reset_dut1", 1, 1'b0, 8'hFF, 8'hFF, 8'hFF); check();

    // PS/2 up key: two-cycle latency, held for two cycles
    ps2(1'b1, 9'h075);
    push("u_latency", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(1); check();
    push("u_press",   0, 1'b0, 8'hFF, 8'hFF, 8'hDF); step(1); check();
    ps2(1'b0, 9'h075);
    push("u_hold",    0, 1'b0, 8'hFF, 8'hFF, 8'hDF); step(1); check();
    push("u_release", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(1); check();

    // Extended down arrow maps to D
    ps2(1'b1, 9'h172);
    push("ext_down", 0, 1'b0, 8'hFF, 8'hFF, 8'hEF); step(2); check();
    ps2(1'b0, 9'h172);
    push("ext_down_rel", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(2); check();

    // Unmapped codes, including extended 014, change nothing
    ps2(1'b1, 9'h05A);
    push("unmapped", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(2); check();
    ps2(1'b1, 9'h114);
    push("ext_014", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(2); check();

    // Keyboard P2 up
    ps2(1'b1, 9'h02D);
    push("kp2_up_c0", 0, 1'b0, 8'hFF, 8'hDF, 8'hDF);
    push("kp2_up_c1", 1, 1'b0, 8'hFF, 8'hDF, 8'hFF);
    step(2); check(); check();
    ps2(1'b0, 9'h02D);
    push("kp2_up_rel", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(2); check();

    // Joystick paths: one-cycle latency
    bus0.joystk2[4] = 1'b1;
    push("j2_t1_c0", 0, 1'b0, 8'hFF, 8'hFD, 8'hFD);
    push("j2_t1_c1", 1, 1'b0, 8'hFF, 8'hFD, 8'hFF);
    step(1); check(); check();
    bus0.joystk2[4] = 1'b0;
    bus0.joystk1[3] = 1'b1;
    push("j1_up", 1, 1'b0, 8'hFF, 8'hFF, 8'hDF); step(1); check();
    bus0.joystk1[3] = 1'b0;
    push("j1_up_rel", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(1); check();

    // Single coin tap then five frames
    bus0.joystk1[9] = 1'b1;
    push("coin_start", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); step(1); check();
    bus0.joystk1[9] = 1'b0;
    for (int i = 0; i < CF + GF; i++) begin
      push($sformatf("coin_frame%0d", i), 0, (i + 1 < CF + GF),
           (i + 1 < CF) ? 8'hFE : 8'hFF, 8'hFF, 8'hFF);
      vb_pulse();
      check();
    end

    // Pending coin: second tap queued, third dropped
    coin_tap();
    push("pend_first", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); check();
    vb_pulse();
    coin_tap();
    step(1);
    coin_tap();
    vb_pulse();
    vb_pulse();
    push("pend_gap", 0, 1'b1, 8'hFF, 8'hFF, 8'hFF); check();
    vb_pulse();
    bus0.vblank = 1'b1;
    push("pend_idle", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(1); check();
    bus0.vblank = 1'b0;
    push("pend_second", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); step(1); check();
    for (int i = 0; i < CF + GF; i++) begin
      push($sformatf("pend_frame%0d", i), 0, (i + 1 < CF + GF),
           (i + 1 < CF) ? 8'hFE : 8'hFF, 8'hFF, 8'hFF);
      vb_pulse();
      check();
    end
    push("third_dropped", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(10); check();

    // F1 acts as Start1 and Coin1
    ps2(1'b1, 9'h005);
    push("f1_press", 0, 1'b1, 8'hEE, 8'hFF, 8'hFF); step(2); check();
    ps2(1'b0, 9'h005);
    push("f1_release", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); step(2); check();
    repeat (CF + GF) vb_pulse();
    push("f1_done", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); check();

    // Held coin produces a single pulse
    bus0.joystk2[9] = 1'b1;
    push("held_start", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); step(1); check();
    repeat (CF + GF) vb_pulse();
    push("held_done", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(5); check();
    bus0.joystk2[9] = 1'b0;
    step(2);

    // Reset during ACTIVE drops the pulse and any pending coin
    coin_tap();
    push("rst_active", 0, 1'b1, 8'hFE, 8'hFF, 8'hFF); check();
    coin_tap();
    reset = 1'b1;
    push("rst_drop", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); step(1); check();
    reset = 1'b0;
    step(1);
    repeat (CF + GF) vb_pulse();
    push("rst_no_pulse", 0, 1'b0, 8'hFF, 8'hFF, 8'hFF); check();

    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d entries required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
